// File: rtl/tx_enqueue.sv
// tx_enqueue: user TX packet interface to TX data FIFO write port.
// Frames words by SOP/EOP, flags nested-SOP errors, and on FIFO overflow
// drops the rest of the frame, closing it with an error-marked terminator.
// Ports:
//   clk_156m25, reset_156m25_n       core clock, async active-low reset
//   pkt_tx_data/val/sop/eop/mod      user packet interface (in)
//   pkt_tx_full                      registered almost-full back-pressure (out)
//   txdfifo_wfull/walmost_full       FIFO flow-control (in)
//   txdfifo_wen/wdata/wstatus        FIFO write port (out, registered)
//   status_txdfifo_ovflow_tog        toggles once per overflow event (out)
module tx_enqueue (
   input  logic        clk_156m25,
   input  logic        reset_156m25_n,
   input  logic [63:0] pkt_tx_data,
   input  logic        pkt_tx_val,
   input  logic        pkt_tx_sop,
   input  logic        pkt_tx_eop,
   input  logic [2:0]  pkt_tx_mod,
   input  logic        txdfifo_wfull,
   input  logic        txdfifo_walmost_full,
   output logic        pkt_tx_full,
   output logic        txdfifo_wen,
   output logic [63:0] txdfifo_wdata,
   output logic [7:0]  txdfifo_wstatus,
   output logic        status_txdfifo_ovflow_tog
);

   localparam int unsigned DATA_W = 64;
   localparam int unsigned STAT_W = 8;
   localparam int unsigned MOD_W  = 3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_IN_PKT = 2'd1;
   localparam logic [1:0] ST_DROP   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              close_pend_q, close_pend_d;
   logic              eop_seen_q, eop_seen_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STAT_W-1:0] wstatus_q, wstatus_d;
   logic              tog_q, tog_d;
   logic              full_q;
   logic              ovf;

   // Status byte layout: {SOP, EOP, ERR, 2'b00, mod}
   function automatic logic [STAT_W-1:0] mk_status(input logic sop, input logic eop,
                                                   input logic err, input logic [MOD_W-1:0] m);
      return {sop, eop, err, 2'b00, m};
   endfunction

   assign ovf = pkt_tx_val & txdfifo_wfull;

   // Next-state and FIFO write decode
   always_comb begin
      state_d      = state_q;
      close_pend_d = close_pend_q;
      eop_seen_d   = eop_seen_q;
      wen_d        = 1'b0;
      wdata_d      = wdata_q;
      wstatus_d    = '0;
      tog_d        = tog_q;

      case (state_q)
         ST_IDLE: begin
            if (ovf) begin
               tog_d = ~tog_q;
               // A single-word packet lost to overflow needs no drop phase
               if (pkt_tx_sop && !pkt_tx_eop) begin
                  state_d      = ST_DROP;
                  close_pend_d = 1'b0;
                  eop_seen_d   = 1'b0;
               end
            end else if (pkt_tx_val && pkt_tx_sop) begin
               wen_d     = 1'b1;
               wdata_d   = pkt_tx_data;
               wstatus_d = mk_status(1'b1, pkt_tx_eop, 1'b0,
                                     pkt_tx_eop ? pkt_tx_mod : MOD_W'(0));
               if (!pkt_tx_eop) begin
                  state_d = ST_IN_PKT;
               end
            end
         end

         ST_IN_PKT: begin
            if (ovf) begin
               // Part of the frame is already in the FIFO: a terminator is owed
               tog_d        = ~tog_q;
               state_d      = ST_DROP;
               close_pend_d = 1'b1;
               eop_seen_d   = pkt_tx_eop;
            end else if (pkt_tx_val && pkt_tx_sop) begin
               // Nested SOP closes the broken frame; the new frame is lost
               wen_d     = 1'b1;
               wdata_d   = pkt_tx_data;
               wstatus_d = mk_status(1'b0, 1'b1, 1'b1, MOD_W'(0));
               state_d   = ST_IDLE;
            end else if (pkt_tx_val) begin
               wen_d     = 1'b1;
               wdata_d   = pkt_tx_data;
               wstatus_d = mk_status(1'b0, pkt_tx_eop, 1'b0,
                                     pkt_tx_eop ? pkt_tx_mod : MOD_W'(0));
               if (pkt_tx_eop) begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_DROP: begin
            if (pkt_tx_val && pkt_tx_eop) begin
               eop_seen_d = 1'b1;
            end
            if (eop_seen_q) begin
               if (!close_pend_q) begin
                  state_d    = ST_IDLE;
                  eop_seen_d = 1'b0;
               end else if (!txdfifo_wfull) begin
                  wen_d        = 1'b1;
                  wdata_d      = '0;
                  wstatus_d    = mk_status(1'b0, 1'b1, 1'b1, MOD_W'(0));
                  state_d      = ST_IDLE;
                  eop_seen_d   = 1'b0;
                  close_pend_d = 1'b0;
               end
            end
         end

         default: begin
            state_d      = ST_IDLE;
            close_pend_d = 1'b0;
            eop_seen_d   = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         state_q      <= ST_IDLE;
         close_pend_q <= 1'b0;
         eop_seen_q   <= 1'b0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wstatus_q    <= '0;
         tog_q        <= 1'b0;
         full_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         close_pend_q <= close_pend_d;
         eop_seen_q   <= eop_seen_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wstatus_q    <= wstatus_d;
         tog_q        <= tog_d;
         full_q       <= txdfifo_walmost_full;
      end
   end

   assign pkt_tx_full               = full_q;
   assign txdfifo_wen               = wen_q;
   assign txdfifo_wdata             = wdata_q;
   assign txdfifo_wstatus           = wstatus_q;
   assign status_txdfifo_ovflow_tog = tog_q;

endmodule

// File: tb/tb_tx_enqueue.sv
// tb_tx_enqueue: directed stimulus with a scoreboard of expected FIFO writes.
module tb_tx_enqueue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] data;
   logic        val, sop, eop;
   logic [2:0]  mod;
   logic        wfull, afull;
   logic        tx_full, wen, tog;
   logic [63:0] wdata;
   logic [7:0]  wstatus;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  s;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic exp_tog = 1'b0;

   tx_enqueue dut (
      .clk_156m25               (clk),
      .reset_156m25_n           (rst_n),
      .pkt_tx_data              (data),
      .pkt_tx_val               (val),
      .pkt_tx_sop               (sop),
      .pkt_tx_eop               (eop),
      .pkt_tx_mod               (mod),
      .txdfifo_wfull            (wfull),
      .txdfifo_walmost_full     (afull),
      .pkt_tx_full              (tx_full),
      .txdfifo_wen              (wen),
      .txdfifo_wdata            (wdata),
      .txdfifo_wstatus          (wstatus),
      .status_txdfifo_ovflow_tog(tog)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one word for one clock, then drop val
   task automatic drive(input logic s, input logic e, input logic [2:0] m,
                        input logic [63:0] d, input logic f);
      val = 1'b1; sop = s; eop = e; mod = m; data = d; wfull = f;
      @(posedge clk); #1;
      val = 1'b0; sop = 1'b0; eop = 1'b0; mod = 3'd0; wfull = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic expect_wr(input logic [63:0] d, input logic [7:0] s);
      exp_t e;
      e.d = d;
      e.s = s;
      exp_q.push_back(e);
   endtask

   // Scoreboard consumer: every write must match the head of the queue
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (wen === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_wen", 64'(wen), 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("wdata", wdata, e.d);
               chk("wstatus", 64'(wstatus), 64'(e.s));
            end
         end else begin
            chk("wstatus_when_idle", 64'(wstatus), 64'd0);
         end
      end
   end

   initial begin
      rst_n = 1'b0; data = '0; val = 1'b0; sop = 1'b0; eop = 1'b0;
      mod = 3'd0; wfull = 1'b0; afull = 1'b0;
      #12;
      chk("rst_wen", 64'(wen), 64'd0);
      chk("rst_wdata", wdata, 64'd0);
      chk("rst_tog", 64'(tog), 64'd0);
      chk("rst_full", 64'(tx_full), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // 3-word packet, mod=5
      expect_wr(64'h1111_0000_0000_0001, 8'h80);
      expect_wr(64'h1111_0000_0000_0002, 8'h00);
      expect_wr(64'h1111_0000_0000_0003, 8'h45);
      drive(1'b1, 1'b0, 3'd0, 64'h1111_0000_0000_0001, 1'b0);
      chk("lat_first_wen", 64'(wen), 64'd1);
      drive(1'b0, 1'b0, 3'd0, 64'h1111_0000_0000_0002, 1'b0);
      drive(1'b0, 1'b1, 3'd5, 64'h1111_0000_0000_0003, 1'b0);
      idle(2);

      // single-word packet
      expect_wr(64'h2222_2222_2222_2222, 8'hC0);
      drive(1'b1, 1'b1, 3'd0, 64'h2222_2222_2222_2222, 1'b0);
      idle(2);

      // val without sop in IDLE is discarded
      drive(1'b0, 1'b0, 3'd0, 64'hDEAD, 1'b0);
      idle(2);
      chk("no_sop_tog", 64'(tog), 64'(exp_tog));

      // nested SOP on word 2; following words discarded
      expect_wr(64'h3333_0000_0000_0001, 8'h80);
      expect_wr(64'h3333_0000_0000_0002, 8'h60);
      drive(1'b1, 1'b0, 3'd0, 64'h3333_0000_0000_0001, 1'b0);
      drive(1'b1, 1'b0, 3'd0, 64'h3333_0000_0000_0002, 1'b0);
      drive(1'b0, 1'b0, 3'd0, 64'h3333_0000_0000_0003, 1'b0);
      drive(1'b0, 1'b1, 3'd2, 64'h3333_0000_0000_0004, 1'b0);
      idle(2);

      // overflow on word 3 of 6, wfull held 2 cycles
      expect_wr(64'h4444_0000_0000_0001, 8'h80);
      expect_wr(64'h4444_0000_0000_0002, 8'h00);
      expect_wr(64'h0, 8'h60);
      drive(1'b1, 1'b0, 3'd0, 64'h4444_0000_0000_0001, 1'b0);
      drive(1'b0, 1'b0, 3'd0, 64'h4444_0000_0000_0002, 1'b0);
      exp_tog = ~exp_tog;
      drive(1'b0, 1'b0, 3'd0, 64'h4444_0000_0000_0003, 1'b1);
      chk("ovf_tog_flip", 64'(tog), 64'(exp_tog));
      drive(1'b0, 1'b0, 3'd0, 64'h4444_0000_0000_0004, 1'b1);
      drive(1'b0, 1'b0, 3'd0, 64'h4444_0000_0000_0005, 1'b0);
      drive(1'b0, 1'b1, 3'd7, 64'h4444_0000_0000_0006, 1'b0);
      idle(2);
      chk("ovf_tog_once", 64'(tog), 64'(exp_tog));
      expect_wr(64'h5555_0000_0000_0001, 8'h80);
      expect_wr(64'h5555_0000_0000_0002, 8'h41);
      drive(1'b1, 1'b0, 3'd0, 64'h5555_0000_0000_0001, 1'b0);
      drive(1'b0, 1'b1, 3'd1, 64'h5555_0000_0000_0002, 1'b0);
      idle(2);

      // overflow on a SOP in IDLE: dropped silently, no terminator
      exp_tog = ~exp_tog;
      drive(1'b1, 1'b0, 3'd0, 64'h6666_0000_0000_0001, 1'b1);
      drive(1'b0, 1'b0, 3'd0, 64'h6666_0000_0000_0002, 1'b0);
      drive(1'b0, 1'b1, 3'd4, 64'h6666_0000_0000_0003, 1'b0);
      idle(2);
      chk("idle_ovf_tog", 64'(tog), 64'(exp_tog));
      expect_wr(64'h7777_7777_7777_7777, 8'hC3);
      drive(1'b1, 1'b1, 3'd3, 64'h7777_7777_7777_7777, 1'b0);
      idle(2);

      // overflow on a single-word packet in IDLE
      exp_tog = ~exp_tog;
      drive(1'b1, 1'b1, 3'd0, 64'h8888, 1'b1);
      chk("sop_eop_ovf_tog", 64'(tog), 64'(exp_tog));
      expect_wr(64'h9999, 8'hC0);
      drive(1'b1, 1'b1, 3'd0, 64'h9999, 1'b0);
      idle(2);

      // almost-full is mirrored one cycle later
      afull = 1'b1;
      chk("full_before", 64'(tx_full), 64'd0);
      @(posedge clk); #1;
      chk("full_rise", 64'(tx_full), 64'd1);
      afull = 1'b0;
      @(posedge clk); #1;
      chk("full_fall", 64'(tx_full), 64'd0);

      // async reset mid-packet
      expect_wr(64'hAAAA_0000_0000_0001, 8'h80);
      drive(1'b1, 1'b0, 3'd0, 64'hAAAA_0000_0000_0001, 1'b0);
      afull = 1'b1;
      @(negedge clk); #1;
      val = 1'b1; data = 64'hAAAA_0000_0000_0002;
      rst_n = 1'b0;
      #1;
      exp_tog = 1'b0;
      chk("mid_rst_wen", 64'(wen), 64'd0);
      chk("mid_rst_wdata", wdata, 64'd0);
      chk("mid_rst_wstatus", 64'(wstatus), 64'd0);
      chk("mid_rst_tog", 64'(tog), 64'(exp_tog));
      chk("mid_rst_full", 64'(tx_full), 64'd0);
      val = 1'b0; afull = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);
      expect_wr(64'hBBBB_BBBB_BBBB_BBBB, 8'hC6);
      drive(1'b1, 1'b1, 3'd6, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
      idle(3);

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tx_enqueue.md
Name: tx_enqueue

Overview:
Transmit-side counterpart of the RX dequeue path. Accepts packets from the user packet interface (pkt_tx_*) and writes them into the TX data FIFO as 64-bit words plus an 8-bit status word. Enforces SOP/EOP framing, flags protocol errors, and handles FIFO overflow by dropping the rest of the frame and closing it in the FIFO with an error-marked terminator. Sits between the user TX interface and the TX data FIFO write port in the 156.25 MHz domain.

Parameters:
none (status bit positions are fixed: TXSTATUS_SOP=7, TXSTATUS_EOP=6, TXSTATUS_ERR=5, bits [4:3]=0, bits [2:0]=modulus)

Ports:
clk_156m25  in  1  core clock
reset_156m25_n  in  1  asynchronous, active-low reset
pkt_tx_data  in  64  user data word
pkt_tx_val  in  1  word valid this cycle
pkt_tx_sop  in  1  first word of packet (qualified by val)
pkt_tx_eop  in  1  last word of packet (qualified by val)
pkt_tx_mod  in  3  valid bytes in EOP word; 0 = all 8
txdfifo_wfull  in  1  FIFO full; guaranteed asserted with at least 1 free entry remaining
txdfifo_walmost_full  in  1  FIFO almost full
pkt_tx_full  out  1  registered copy of txdfifo_walmost_full; user must stop issuing val
txdfifo_wen  out  1  FIFO write enable
txdfifo_wdata  out  64  FIFO write data
txdfifo_wstatus  out  8  FIFO write status {SOP,EOP,ERR,2'b0,mod}
status_txdfifo_ovflow_tog  out  1  toggles once per overflow event (interrupt source)

Behaviour:
- One clock; reset is asynchronous and active-low (clk_156m25 / reset_156m25_n). All outputs and state reset to 0, state = IDLE, close_pend = 0.
- All FIFO outputs are registered, with 1-cycle latency from the accepted input to txdfifo_wen. txdfifo_wdata holds its value when wen=0. wstatus is 0 when wen=0.
- pkt_tx_full <= txdfifo_walmost_full every cycle.
- Overflow condition: ovf = pkt_tx_val & txdfifo_wfull, sampled in the acceptance cycle. An ovf word is never written. status_txdfifo_ovflow_tog toggles on each ovf cycle in IDLE or IN_PKT only, not in DROP.
- States:
  - IDLE:
    - val&sop&!ovf: write word with SOP=1. If eop is also set, write EOP=1 and mod, and stay in IDLE. Otherwise go to IN_PKT.
    - val&sop&ovf: go to DROP with close_pend=0, unless eop is also set, in which case stay in IDLE.
    - val&!sop: discard silently, no write, stay in IDLE.
  - IN_PKT:
    - val&!sop&!ovf: write word. If eop, set EOP=1 and mod, and go to IDLE.
    - val&sop&!ovf (nested SOP): write the word with EOP=1, ERR=1, mod=0, closing the broken packet, and go to IDLE. The new packet is lost.
    - val&ovf: go to DROP with close_pend=1. If this word carries eop, also set eop_seen=1.
    - !val: hold state.
  - DROP:
    - Discard all val words. Set eop_seen on val&eop.
    - When eop_seen=1 and close_pend=1 and !txdfifo_wfull: write terminator word (data=0, status EOP=1, ERR=1, mod=0), clear flags, go to IDLE.
    - When eop_seen=1 and close_pend=0: go to IDLE the next cycle, no write.
    - A val&sop arriving in DROP before eop_seen is discarded.
- mod is written only on EOP words. The SOP+EOP single-word packet carries both flags.
- Reset mid-packet clears all state. Any partial packet already in the FIFO is the FIFO's reset responsibility.

Test Plan:
- 3-word packet (sop, -, eop, mod=5), FIFO empty -> wen high for 3 cycles starting 1 cycle after input; wstatus = 0x80, 0x00, 0x45; state returns to IDLE.
- Single-word packet with sop=eop=1, mod=0 -> one write with wstatus=0xC0.
- val without sop in IDLE (data 0xDEAD) -> no wen, no toggle.
- Nested SOP on word 2 of a packet -> word 2 written with wstatus=0x60; the following non-SOP words are discarded.
- wfull asserted on word 3 of a 6-word packet, deasserted 2 cycles later -> words 3..6 not written, ovflow_tog flips once; after EOP, a terminator is written with data=0 and wstatus=0x60; a subsequent packet is written normally.
- txdfifo_walmost_full pulses 1 -> pkt_tx_full follows 1 cycle later; async reset asserted mid-packet -> all outputs 0 immediately, and the next SOP is accepted from IDLE.
